// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA shift controller with a start/busy/done handshake.
// Optional build macro SHIFT_STEP4_EN: shift by 4 per cycle while count >= 4.
module shift_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               big_step;
  logic [SHAMT_W-1:0] step_amt;
  op_e                op_in;

  assign op_in = op_e'(op);

  // One shift step of 1 or 4 bit positions; fill rules depend only on op.
  function automatic logic [DATA_W-1:0] shift_step(
    input logic [DATA_W-1:0] v,
    input op_e               o,
    input logic              by4
  );
    logic [DATA_W-1:0] r;
    r = v;
    case (o)
      OP_SLL:  r = by4 ? (v << 4) : (v << 1);
      OP_SRL:  r = by4 ? (v >> 4) : (v >> 1);
      OP_SRA:  r = by4 ? DATA_W'($signed(v) >>> 4) : DATA_W'($signed(v) >>> 1);
      default: r = v;
    endcase
    return r;
  endfunction

`ifdef SHIFT_STEP4_EN
  assign big_step = (count_q > SHAMT_W'(3));
`else
  assign big_step = 1'b0;
`endif

  assign step_amt = big_step ? SHAMT_W'(4) : SHAMT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          result_d = data_in;
          op_d     = op_in;
          count_d  = shamt;
          state_d  = (shamt == '0 || op_in == OP_PASS) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        result_d = shift_step(result_q, op_q, big_step);
        count_d  = count_q - step_amt;
        if (count_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_SLL;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed cases plus random traffic
// against a one-shot arithmetic shift model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  shift_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          busy_cnt = 0;
  logic [31:0] last_result = 32'h0;
  bit          have_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int n);
    case (o)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return 32'($signed(d) >>> n);
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input int n);
    if (n == 0 || o == 2'b11) return 0;
`ifdef SHIFT_STEP4_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Drive one request at a negedge, push its expectation, then fill its busy
  // window with junk requests that must be ignored. Returns one negedge
  // before the DONE cycle, so the caller may issue back-to-back.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input int n, input bit junk);
    exp_t e;
    int   l;
    @(negedge clk);
    l = ref_lat(o, n);
    start = 1'b1; op = o; data_in = d; shamt = 5'(n);
    e.res = ref_shift(o, d, n);
    e.done_cyc = cyc + 1 + l;
    e.lat = l;
    sb.push_back(e);
    for (int j = 0; j < l; j++) begin
      @(negedge clk);
      start   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      op      = 2'($urandom_range(0, 3));
      data_in = $urandom;
      shamt   = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Monitor: pops on every done pulse; also checks busy length and result hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt    = 0;
      last_result = 32'h0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && done) check("busy_and_done", {busy, done}, 2'b01);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt    = 0;
        last_result = result;
        have_last   = 1;
      end else if (!busy && have_last) begin
        check("result_hold", result, last_result);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; data_in = 32'h0; shamt = 5'd0;
    @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    issue(2'b00, 32'h0000_0001, 31, 1'b0);
    idle(1);
    issue(2'b10, 32'h8000_0000, 4, 1'b0);
    issue(2'b01, 32'h8000_0000, 4, 1'b0);
    idle(2);
    issue(2'b00, 32'hDEAD_BEEF, 0, 1'b0);
    issue(2'b11, 32'hDEAD_BEEF, 7, 1'b0);
    idle(1);
    issue(2'b00, 32'h0000_0001, 5, 1'b0);
    idle(1);
    issue(2'b01, 32'hF0F0_1234, 10, 1'b1);
    idle(2);

    // Abort mid-operation: no expectation is pushed, so any done is flagged.
    @(negedge clk);
    start = 1'b1; op = 2'b01; data_in = 32'h1234_5678; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("abort_idle_done", 32'(done), 32'h0);

    for (int t = 0; t < 250; t++) begin
      logic [1:0] o;
      int         n;
      o = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8));
      issue(o, $urandom, n, 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
